mmss_bcd_counter: RTL and testbench
===================================

Name: mmss_bcd_counter

Overview:
- Time-keeping core of the stopwatch.
- Holds minutes:seconds as four BCD digits and runs, pauses, or enters adjust mode from debounced button/switch levels.
- Sits directly upstream of the digit-to-segment decoders and display mux, which consume its four digit outputs.
- All logic runs on the single system clock; tick_1hz and tick_2hz are one-cycle enables from the clock-divider block, not derived clocks.

Parameters:
- START_PAUSED, 0, 1 = state after reset is PAUSED; 0 = RUN.
- MAX_MIN, 59, highest minute value (1..99). Minutes wrap MAX_MIN -> 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle count enable, 1 Hz.
- tick_2hz  in  1  one-cycle adjust enable, 2 Hz.
- pause_lvl  in  1  debounced pause button level; each rising edge toggles RUN/PAUSED.
- adj  in  1  adjust-mode switch level.
- sel  in  1  adjust field select: 0 = minutes, 1 = seconds.
- lap_lvl  in  1  debounced lap button level (used only with LAP_HOLD_EN).
- min_tens  out  4  BCD minutes tens.
- min_ones  out  4  BCD minutes ones.
- sec_tens  out  4  BCD seconds tens, 0..5.
- sec_ones  out  4  BCD seconds ones, 0..9.
- running  out  1  1 while state == RUN.
- rollover  out  1  one-cycle pulse on MAX_MIN:59 -> 00:00 in RUN.

Behaviour:
- Reset (rst=1 at posedge clk):
  - All digits = 0, rollover = 0.
  - State = PAUSED if START_PAUSED else RUN; running follows the state.
  - pause_q is loaded with pause_lvl, so a button held through reset does not toggle on release.
- Edge detect: pause_rise = pause_lvl & ~pause_q; pause_q <= pause_lvl every cycle.
- States: RUN, PAUSED, ADJUST. All actions are decided from the registered state of the current cycle.
  - RUN:
    - adj=1 -> ADJUST next cycle.
    - Else pause_rise -> PAUSED.
    - On tick_1hz (including the cycle of pause_rise), seconds increment.
  - PAUSED:
    - adj=1 -> ADJUST.
    - Else pause_rise -> RUN.
    - tick_1hz is ignored, including in the same cycle as pause_rise.
  - ADJUST:
    - adj=0 -> PAUSED, always; no auto-resume.
    - pause_rise and tick_1hz are ignored.
    - On tick_2hz, the selected field (sel sampled that cycle) increments.
- Seconds increment in RUN:
  - sec_ones 9 -> 0 with carry into sec_tens.
  - sec_tens 5 with carry -> 0 with carry into minutes.
  - Minutes increment as a BCD pair; MAX_MIN -> 00.
  - MAX_MIN:59 -> 00:00 asserts rollover for exactly that update cycle.
- Adjust increment:
  - Seconds field: 59 -> 00 with no carry into minutes.
  - Minutes field: MAX_MIN -> 00.
  - rollover is never asserted in ADJUST.
- Digits never hold non-BCD values; sec_tens never exceeds 5.
- Outputs are registered: a counting tick at cycle N is visible at cycle N+1.
- Reset asserted mid-count or mid-adjust overrides every other input that cycle.

Optional Feature:
- Macro LAP_HOLD_EN.
- Defined:
  - A rising edge of lap_lvl (edge-detected and reset-loaded like pause) in RUN or PAUSED toggles a hold flag.
  - Setting hold snapshots the live count into the output digit registers; the outputs then stay frozen while the internal count keeps running.
  - Clearing hold makes the outputs track live again from the next cycle.
  - Hold is cleared by rst and on entry to ADJUST.
  - running and rollover always reflect live state.
- Not defined: lap_lvl is ignored and the outputs always equal the live count.

Test Plan:
- Reset with START_PAUSED=0, then 75 tick_1hz pulses -> digits 0,1,1,5 (01:15); running=1.
- Preload 59:58 via ADJUST, exit, toggle to RUN, 2 ticks -> 00:00; rollover high for exactly 1 cycle after the second tick.
- In RUN at 00:10, pause_rise and tick_1hz in the same cycle -> shows 00:11, running=0; 3 further ticks -> still 00:11.
- adj=1, sel=1 at 00:58, 3 tick_2hz -> 00:01 (no minute carry); sel=0, 2 tick_2hz -> 02:01; adj=0 -> PAUSED, tick_1hz ignored.
- pause_lvl held high through reset release -> no toggle; the first rising edge after release toggles the state.
- LAP_HOLD_EN: lap edge at 00:05, 10 ticks -> outputs stay 00:05; second lap edge -> outputs 00:15 next cycle.

Source files
------------

// File: rtl/mmss_bcd_counter.sv
// -----------------------------------------------------------------------------
// mmss_bcd_counter
// Time-keeping core of the stopwatch. Holds minutes:seconds as four BCD digits
// and runs, pauses or enters adjust mode from debounced button/switch levels.
// All logic runs on clk; tick_1hz / tick_2hz are one-cycle enables.
//
// Parameters:
//   START_PAUSED : 1 = state after reset is PAUSED, 0 = RUN
//   MAX_MIN      : highest minute value (1..99); minutes wrap MAX_MIN -> 00
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   tick_1hz   in   one-cycle count enable (1 Hz)
//   tick_2hz   in   one-cycle adjust enable (2 Hz)
//   pause_lvl  in   debounced pause button level; rising edge toggles RUN/PAUSED
//   adj        in   adjust-mode switch level
//   sel        in   adjust field select: 0 = minutes, 1 = seconds
//   lap_lvl    in   debounced lap button level (LAP_HOLD_EN builds only)
//   min_tens   out  BCD minutes tens
//   min_ones   out  BCD minutes ones
//   sec_tens   out  BCD seconds tens (0..5)
//   sec_ones   out  BCD seconds ones (0..9)
//   running    out  1 while in RUN
//   rollover   out  one-cycle pulse on MAX_MIN:59 -> 00:00 while running
//
// Optional feature macro: LAP_HOLD_EN
//   When defined, a rising edge of lap_lvl in RUN or PAUSED toggles a hold
//   flag that freezes the digit outputs while the internal count continues.
// -----------------------------------------------------------------------------
module mmss_bcd_counter #(
    parameter int START_PAUSED = 0,
    parameter int MAX_MIN      = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_lvl,
    input  logic       adj,
    input  logic       sel,
    input  logic       lap_lvl,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);
    localparam state_t     RESET_STATE  = (START_PAUSED != 0) ? ST_PAUSED : ST_RUN;

    // Minutes BCD pair increment, wrapping MAX_MIN -> 00. Returns {tens, ones}.
    function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] res;
        if ((tens == MAX_MIN_TENS) && (ones == MAX_MIN_ONES)) begin
            res = 8'h00;
        end else if (ones == 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones + 4'd1};
        end
        return res;
    endfunction

    // Seconds BCD pair increment, 59 -> 00. Returns {carry_out, tens, ones}.
    function automatic logic [8:0] sec_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] res;
        if (ones != 4'd9) begin
            res = {1'b0, tens, ones + 4'd1};
        end else if (tens != 4'd5) begin
            res = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            res = {1'b1, 4'd0, 4'd0};
        end
        return res;
    endfunction

    state_t     state_r, state_next_s;
    logic       pause_q_r;
    logic       pause_rise_s;
    logic [3:0] cnt_mt_r, cnt_mo_r, cnt_st_r, cnt_so_r;
    logic [3:0] cnt_mt_s, cnt_mo_s, cnt_st_s, cnt_so_s;
    logic [3:0] out_mt_r, out_mo_r, out_st_r, out_so_r;
    logic       rollover_r, rollover_s;
    logic       hold_next_s;
    logic [8:0] sec_step_s;
    logic [7:0] min_step_s;

    assign pause_rise_s = pause_lvl & ~pause_q_r;
    assign sec_step_s   = sec_inc(cnt_st_r, cnt_so_r);
    assign min_step_s   = min_inc(cnt_mt_r, cnt_mo_r);

    // Next-state and next-count decode from the registered state.
    always_comb begin
        state_next_s = state_r;
        cnt_mt_s     = cnt_mt_r;
        cnt_mo_s     = cnt_mo_r;
        cnt_st_s     = cnt_st_r;
        cnt_so_s     = cnt_so_r;
        rollover_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (adj) begin
                    state_next_s = ST_ADJUST;
                end else if (pause_rise_s) begin
                    state_next_s = ST_PAUSED;
                end else begin
                    state_next_s = ST_RUN;
                end
                // Counting still happens on the cycle the pause edge arrives.
                if (tick_1hz) begin
                    cnt_st_s = sec_step_s[7:4];
                    cnt_so_s = sec_step_s[3:0];
                    if (sec_step_s[8]) begin
                        cnt_mt_s = min_step_s[7:4];
                        cnt_mo_s = min_step_s[3:0];
                        rollover_s = (cnt_mt_r == MAX_MIN_TENS) && (cnt_mo_r == MAX_MIN_ONES);
                    end else begin
                        rollover_s = 1'b0;
                    end
                end else begin
                    rollover_s = 1'b0;
                end
            end
            ST_PAUSED: begin
                if (adj) begin
                    state_next_s = ST_ADJUST;
                end else if (pause_rise_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            ST_ADJUST: begin
                // Leaving adjust always lands in PAUSED; the user resumes explicitly.
                if (!adj) begin
                    state_next_s = ST_PAUSED;
                end else begin
                    state_next_s = ST_ADJUST;
                end
                if (tick_2hz) begin
                    if (sel) begin
                        // Seconds wrap on their own; no carry into minutes here.
                        cnt_st_s = sec_step_s[7:4];
                        cnt_so_s = sec_step_s[3:0];
                    end else begin
                        cnt_mt_s = min_step_s[7:4];
                        cnt_mo_s = min_step_s[3:0];
                    end
                end else begin
                    cnt_st_s = cnt_st_r;
                end
            end
            default: begin
                state_next_s = RESET_STATE;
            end
        endcase
    end

`ifdef LAP_HOLD_EN
    logic lap_q_r;
    logic hold_r;
    logic lap_rise_s;

    assign lap_rise_s = lap_lvl & ~lap_q_r;

    // Hold flag decode: cleared on entry to adjust, toggled by lap edges otherwise.
    always_comb begin
        hold_next_s = hold_r;
        if ((state_next_s == ST_ADJUST) && (state_r != ST_ADJUST)) begin
            hold_next_s = 1'b0;
        end else if ((state_r != ST_ADJUST) && lap_rise_s) begin
            hold_next_s = ~hold_r;
        end else begin
            hold_next_s = hold_r;
        end
    end

    // Lap edge detector and hold flag; lap_q loads the live level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q_r <= lap_lvl;
            hold_r  <= 1'b0;
        end else begin
            lap_q_r <= lap_lvl;
            hold_r  <= hold_next_s;
        end
    end
`else
    logic unused_lap_s;
    assign unused_lap_s = lap_lvl;
    assign hold_next_s  = 1'b0;
`endif

    // State, edge detector and live count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RESET_STATE;
            pause_q_r  <= pause_lvl;
            cnt_mt_r   <= 4'd0;
            cnt_mo_r   <= 4'd0;
            cnt_st_r   <= 4'd0;
            cnt_so_r   <= 4'd0;
            rollover_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pause_q_r  <= pause_lvl;
            cnt_mt_r   <= cnt_mt_s;
            cnt_mo_r   <= cnt_mo_s;
            cnt_st_r   <= cnt_st_s;
            cnt_so_r   <= cnt_so_s;
            rollover_r <= rollover_s;
        end
    end

    // Output digit registers: follow the live count unless a lap hold is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_mt_r <= 4'd0;
            out_mo_r <= 4'd0;
            out_st_r <= 4'd0;
            out_so_r <= 4'd0;
        end else if (!hold_next_s) begin
            out_mt_r <= cnt_mt_s;
            out_mo_r <= cnt_mo_s;
            out_st_r <= cnt_st_s;
            out_so_r <= cnt_so_s;
        end else begin
            out_mt_r <= out_mt_r;
            out_mo_r <= out_mo_r;
            out_st_r <= out_st_r;
            out_so_r <= out_so_r;
        end
    end

    assign min_tens = out_mt_r;
    assign min_ones = out_mo_r;
    assign sec_tens = out_st_r;
    assign sec_ones = out_so_r;
    assign running  = (state_r == ST_RUN);
    assign rollover = rollover_r;

endmodule

// File: tb/tb_mmss_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_mmss_bcd_counter
// Directed-vector bench for mmss_bcd_counter (START_PAUSED=0, MAX_MIN=59).
// Stimulus pushes hand-computed expectations into a queue; a monitor on the
// falling clock edge pops each one and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mmss_bcd_counter;

    typedef struct {
        string      name;
        logic [15:0] digits;
        logic       run;
        logic       roll;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause_lvl = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic       lap_lvl = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, rollover;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    bit   stim_done = 1'b0;

    mmss_bcd_counter #(.START_PAUSED(0), .MAX_MIN(59)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .pause_lvl(pause_lvl), .adj(adj), .sel(sel), .lap_lvl(lap_lvl),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .running(running), .rollover(rollover)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [15:0] digits,
                              input logic run, input logic roll);
        exp_t e;
        e.name = name; e.digits = digits; e.run = run; e.roll = roll;
        exp_q.push_back(e);
    endtask

    task automatic tick1(input int n);
        tick_1hz = 1'b1;
        repeat (n) cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic tick2(input int n);
        tick_2hz = 1'b1;
        repeat (n) cyc();
        tick_2hz = 1'b0;
    endtask

    // Monitor: compare every pending expectation half a cycle after it was issued.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if ({min_tens, min_ones, sec_tens, sec_ones} !== e.digits) begin
                tests_failed++;
                $display("FAIL %s digits: got %h want %h", e.name,
                         {min_tens, min_ones, sec_tens, sec_ones}, e.digits);
            end
            tests_run++;
            if (running !== e.run) begin
                tests_failed++;
                $display("FAIL %s running: got %b want %b", e.name, running, e.run);
            end
            tests_run++;
            if (rollover !== e.roll) begin
                tests_failed++;
                $display("FAIL %s rollover: got %b want %b", e.name, rollover, e.roll);
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        cyc();
        expect_out("reset", 16'h0000, 1'b1, 1'b0);
        rst = 1'b0;

        // 75 seconds of counting
        tick1(75);
        expect_out("count_75", 16'h0115, 1'b1, 1'b0);

        // Reset mid-count overrides a concurrent tick
        rst = 1'b1; tick_1hz = 1'b1;
        cyc();
        rst = 1'b0; tick_1hz = 1'b0;
        expect_out("reset_midcount", 16'h0000, 1'b1, 1'b0);

        // Pause edge and tick in the same cycle
        tick1(10);
        expect_out("count_10", 16'h0010, 1'b1, 1'b0);
        pause_lvl = 1'b1; tick_1hz = 1'b1;
        cyc();
        pause_lvl = 1'b0; tick_1hz = 1'b0;
        expect_out("pause_tick", 16'h0011, 1'b0, 1'b0);
        tick1(3);
        expect_out("paused_ignore", 16'h0011, 1'b0, 1'b0);

        // Adjust seconds without carry, then minutes
        adj = 1'b1; sel = 1'b1;
        cyc();
        expect_out("enter_adjust", 16'h0011, 1'b0, 1'b0);
        tick_1hz = 1'b1;
        tick2(47);
        tick_1hz = 1'b0;
        expect_out("adj_sec_58", 16'h0058, 1'b0, 1'b0);
        tick2(3);
        expect_out("adj_sec_wrap", 16'h0001, 1'b0, 1'b0);
        sel = 1'b0;
        tick2(2);
        expect_out("adj_min", 16'h0201, 1'b0, 1'b0);
        adj = 1'b0;
        cyc();
        tick1(3);
        expect_out("exit_adjust_paused", 16'h0201, 1'b0, 1'b0);

        // Preload 59:58 and check the minute wrap in adjust
        adj = 1'b1; sel = 1'b0;
        cyc();
        tick2(57);
        expect_out("adj_min_59", 16'h5901, 1'b0, 1'b0);
        tick2(1);
        expect_out("adj_min_wrap", 16'h0001, 1'b0, 1'b0);
        tick2(59);
        sel = 1'b1;
        tick2(57);
        expect_out("preload", 16'h5958, 1'b0, 1'b0);
        adj = 1'b0;
        cyc();
        pause_lvl = 1'b1;
        cyc();
        pause_lvl = 1'b0;
        expect_out("resume", 16'h5958, 1'b1, 1'b0);
        tick1(1);
        expect_out("at_5959", 16'h5959, 1'b1, 1'b0);
        tick1(1);
        expect_out("rollover_pulse", 16'h0000, 1'b1, 1'b1);
        cyc();
        expect_out("rollover_clear", 16'h0000, 1'b1, 1'b0);

        // Pause held through reset must not toggle on release
        pause_lvl = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_out("reset_pause_held", 16'h0000, 1'b1, 1'b0);
        cyc(); cyc();
        expect_out("held_no_toggle", 16'h0000, 1'b1, 1'b0);
        pause_lvl = 1'b0;
        cyc();
        expect_out("release_no_toggle", 16'h0000, 1'b1, 1'b0);
        pause_lvl = 1'b1;
        cyc();
        pause_lvl = 1'b0;
        expect_out("first_edge_toggles", 16'h0000, 1'b0, 1'b0);

        // Lap behaviour
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tick1(5);
        expect_out("lap_start", 16'h0005, 1'b1, 1'b0);
        lap_lvl = 1'b1;
        cyc();
        lap_lvl = 1'b0;
        tick1(10);
`ifdef LAP_HOLD_EN
        expect_out("lap_frozen", 16'h0005, 1'b1, 1'b0);
`else
        expect_out("lap_ignored", 16'h0015, 1'b1, 1'b0);
`endif
        lap_lvl = 1'b1;
        cyc();
        lap_lvl = 1'b0;
        expect_out("lap_release", 16'h0015, 1'b1, 1'b0);

        cyc(); cyc();
        stim_done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
